// File: rtl/btn_conditioner.sv
// Push-button front end: 2-flop synchronisers, per-key debouncers, and a
// priority-encoded active-low key code (one-cycle pulse or held level).

// One key's debouncer: the accepted level moves only after DEBOUNCE_CYCLES
// consecutive disagreeing samples; any agreement discards the partial count.
module btn_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_i,
  output logic level_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  // Count disagreements; accept the new level at the threshold and clear.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_i == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync_i;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter and accepted level; keys come out of reset released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
endmodule

module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1,
  parameter int PULSE_MODE      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_raw,
  output logic [2:0] btn,
  output logic [2:0] btn_level,
  output logic       press_valid
);
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] level_prev_q;
  logic [2:0] btn_q, btn_d;
  logic       press_valid_q, press_valid_d;
  logic [2:0] fall;
  logic [2:0] sel;

  // Two-flop synchroniser per key; resets to "released".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    btn_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .sync_i (sync2_q[gi]),
      .level_o(btn_level[gi])
    );
  end

  // Press = debounced level went 1 -> 0 since last cycle.
  assign fall = level_prev_q & ~btn_level;
  // Pulse mode encodes new presses only; hold mode encodes every held key.
  assign sel  = (PULSE_MODE != 0) ? fall : ~btn_level;

  // Fixed priority key 0 > key 1 > key 2; losers are dropped, not queued.
  always_comb begin
    btn_d = 3'b111;
    if (sel[0])      btn_d = 3'b110;
    else if (sel[1]) btn_d = 3'b101;
    else if (sel[2]) btn_d = 3'b011;
    press_valid_d = (btn_d != 3'b111);
  end

  // Registered outputs plus the previous level used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_prev_q  <= 3'b111;
      btn_q         <= 3'b111;
      press_valid_q <= 1'b0;
    end else begin
      level_prev_q  <= btn_level;
      btn_q         <= btn_d;
      press_valid_q <= press_valid_d;
    end
  end

  assign btn         = btn_q;
  assign press_valid = press_valid_q;
endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end stage for the board push-buttons, sitting directly upstream of the memory-write decoder.
- Synchronises and debounces the 3 raw active-low keys.
- Presents the decoder with a clean 3-bit active-low code in which at most one bit is low at a time: a single-cycle pulse per press, or a held level.
- Also exports debounced levels and a press strobe for status logic.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a new key state (10 ms at 50 MHz); legal range >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1: width of each per-key stability counter.
- PULSE_MODE, 1: 1 = btn output is a one-cycle pulse per press; 0 = btn output follows the held key.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- btn_raw  input  3  raw keys, active-low (0 = pressed), asynchronous to clk
- btn  output  3  conditioned key code to the write decoder, active-low; idle 3'b111; never more than one bit low
- btn_level  output  3  debounced key levels, active-low, all keys, no priority
- press_valid  output  1  high for exactly the cycle(s) btn is not 3'b111

Behaviour:
- Reset (async assert, release synchronous to clk):
  - sync flops, btn_level and btn = 3'b111
  - counters = 0
  - press_valid = 0
- Synchroniser: 2-flop chain per key, reset value 1. sync = second stage.
- Debounce, per key i, every clk edge:
  - sync[i] == btn_level[i]: counter cleared to 0.
  - mismatch and counter < DEBOUNCE_CYCLES-1: counter increments.
  - mismatch and counter == DEBOUNCE_CYCLES-1: btn_level[i] <= sync[i], counter cleared.
  - Any return to agreement before the threshold discards the partial count (glitch rejected).
- Latency: a clean raw change registered by sync stage 1 at edge E0 updates btn_level at edge E(1+DEBOUNCE_CYCLES).
- Press event: falling transition of btn_level[i] (1 to 0), detected against the previous-cycle btn_level.
- Priority when several keys are active in the same cycle: key 0 > key 1 > key 2. Lower-priority press events in that cycle are dropped, not queued.
- PULSE_MODE=1:
  - btn is registered. On the edge after a press event, btn = 3'b111 with the winning bit cleared, for exactly one cycle, then returns to 3'b111.
  - A held key never re-pulses.
  - A release produces no output.
- PULSE_MODE=0:
  - btn (registered) shows the highest-priority currently debounced-low key, i.e. a one-bit-low code.
  - Updates one cycle after btn_level.
  - Releasing the winning key while another is held switches btn to that key on the next cycle.
- press_valid = registered (btn != 3'b111), aligned with btn.
- Counters saturate-free by construction; no wrap can occur because the count is cleared at threshold.
- Reset mid-debounce: partial counts lost.
  - A key held through reset is seen as released at reset exit.
  - It therefore yields one new press after DEBOUNCE_CYCLES of stable low (defined behaviour, not an error).
- Reset mid-pulse: btn forced to 3'b111 immediately (async).

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press: btn_raw[0] 1->0 held 20 cycles -> btn_level[0] falls 5 edges after first sync capture; btn = 3'b110 and press_valid = 1 for exactly one cycle on the next edge; no further pulse while held; release produces nothing.
- Bounce rejection: btn_raw[1] low 3 cycles, high 1, low 2, high -> btn_level stays 3'b111, btn stays 3'b111, press_valid never asserted.
- Simultaneous press: btn_raw 3'b111 -> 3'b100 on the same edge -> single pulse btn = 3'b110; key 1 dropped; btn_level = 3'b100.
- Hold mode (PULSE_MODE=0): hold keys 2 then 1 -> btn = 3'b011, then 3'b101 once key 1 is debounced; release key 1 -> btn = 3'b011 one cycle after btn_level[1] rises.
- Reset mid-operation: assert rst during a pulse and while key 2 is held low -> btn = 3'b111 asynchronously; after release, exactly one 3'b011 pulse occurs 6 edges after rst deassertion (2 sync edges + 4 debounce edges), no earlier.
